// File: rtl/alu_mdu_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package alu_mdu_seq_pkg;

  typedef enum logic [2:0] {
    MdOpMulW   = 3'd0,
    MdOpMulhW  = 3'd1,
    MdOpMulhWu = 3'd2,
    MdOpRsvd   = 3'd3,
    MdOpDivW   = 3'd4,
    MdOpModW   = 3'd5,
    MdOpDivWu  = 3'd6,
    MdOpModWu  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MduStIdle = 2'd0,
    MduStCalc = 2'd1,
    MduStFin  = 2'd2
  } mdu_state_e;

  localparam logic [31:0] DivZeroQuot = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MdOpMulhW) || (op == MdOpDivW) || (op == MdOpModW);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_step_unit.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module alu_mdu_seq_step_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,    // product high half or partial remainder
  input  logic [XLEN-1:0] lo_i,     // multiplier bits or dividend/quotient bits
  input  logic [XLEN-1:0] opb_i,    // multiplicand or divisor magnitude
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   addend;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    addend  = lo_i[0] ? {1'b0, opb_i} : '0;
    add_sum = {1'b0, acc_i} + addend;
    shifted = {acc_i, lo_i[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_i};
    acc_o   = acc_i;
    lo_o    = lo_i;
    if (is_div_i) begin
      // Remainder stays below the divisor, so the low XLEN bits are always enough.
      if (!diff[XLEN+1]) begin
        acc_o = diff[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shifted[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = add_sum[XLEN:1];
      lo_o  = {add_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Iterative LoongArch mul/div sequencer (32-cycle radix-2 datapath).
// Optional MDU_FAST_MUL_EN: single-cycle multiply for ops 0-2.
module alu_mdu_seq
  import alu_mdu_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  mdu_state_e      state_q, state_d;
  md_op_e          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            b_zero_q, b_zero_d;
  logic            div_zero_q, div_zero_d;

  logic [XLEN-1:0] step_acc, step_lo;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, final_res;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;

  always_comb begin
    ext_a = {{XLEN{1'b0}}, src_a};
    ext_b = {{XLEN{1'b0}}, src_b};
    if (md_op == MdOpMulhW) begin
      ext_a = {{XLEN{src_a[XLEN-1]}}, src_a};
      ext_b = {{XLEN{src_b[XLEN-1]}}, src_b};
    end
    // Low 2*XLEN bits of the sign-extended product equal the signed product.
    fast_prod = ext_a * ext_b;
  end
`endif

  alu_mdu_seq_step_unit #(
    .XLEN(XLEN)
  ) u_step (
    .is_div_i(op_q[2]),
    .acc_i   (acc_q),
    .lo_i    (lo_q),
    .opb_i   (opb_q),
    .acc_o   (step_acc),
    .lo_o    (step_lo)
  );

  always_comb begin
    a_neg = op_is_signed(md_op) & src_a[XLEN-1];
    b_neg = op_is_signed(md_op) & src_b[XLEN-1];
    a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag = b_neg ? (~src_b + 1'b1) : src_b;
  end

  // Sign fixup applied to the outcome of the final iteration.
  always_comb begin
    prod_fix = neg_q ? (~{step_acc, step_lo} + 1'b1) : {step_acc, step_lo};
    quot_fix = neg_q ? (~step_lo + 1'b1) : step_lo;
    rem_fix  = rem_neg_q ? (~step_acc + 1'b1) : step_acc;
    unique case (op_q)
      MdOpMulW:              final_res = prod_fix[XLEN-1:0];
      MdOpMulhW, MdOpMulhWu: final_res = prod_fix[2*XLEN-1:XLEN];
      MdOpRsvd:              final_res = '0;
      MdOpDivW, MdOpDivWu:   final_res = b_zero_q ? DivZeroQuot : quot_fix;
      MdOpModW, MdOpModWu:   final_res = rem_fix;
      default:               final_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    result_d   = result_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    b_zero_d   = b_zero_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      MduStIdle, MduStFin: begin
        state_d = MduStIdle;
        if (start && !flush) begin
          state_d   = MduStCalc;
          op_d      = md_op_e'(md_op);
          cnt_d     = '0;
          acc_d     = '0;
          // Divide shifts the dividend out of lo; multiply shifts the multiplier.
          lo_d      = md_op[2] ? a_mag : b_mag;
          opb_d     = md_op[2] ? b_mag : a_mag;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          b_zero_d  = (src_b == '0);
`ifdef MDU_FAST_MUL_EN
          if (md_op == MdOpMulW || md_op == MdOpMulhW || md_op == MdOpMulhWu) begin
            state_d    = MduStFin;
            result_d   = (md_op == MdOpMulW) ? fast_prod[XLEN-1:0]
                                             : fast_prod[2*XLEN-1:XLEN];
            div_zero_d = 1'b0;
          end
`endif
        end
      end
      MduStCalc: begin
        if (flush) begin
          state_d = MduStIdle;
        end else begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d    = MduStFin;
            result_d   = final_res;
            div_zero_d = op_q[2] & b_zero_q;
          end
        end
      end
      default: state_d = MduStIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MduStIdle;
      op_q       <= MdOpMulW;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      b_zero_q   <= b_zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == MduStCalc);
  assign done     = (state_q == MduStFin);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq (default build, iterative multiply).
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mdu_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .md_op   (md_op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .div_zero(div_zero)
  );

  // Reference: plain 64-bit arithmetic from the instruction definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ua, ub, p;
    longint      sa, sb, t;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin t = sa * sb; p = t; return p[63:32]; end
      3'd2: begin p = ua * ub; return p[63:32]; end
      3'd3: return 32'h0;
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        t = sa / sb; p = t; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return a;
        t = sa % sb; p = t; return p[31:0];
      end
      3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic ref_dz(input logic [2:0] op, input logic [31:0] b);
    return op[2] && (b == 0);
  endfunction

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic dz, output int lat,
                        output int bcnt);
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      bcnt += busy ? 1 : 0;
    end
    res = result;
    dz  = div_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b div_zero=%b result=%h, want 0/0/0/0",
               busy, done, div_zero, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  ops[13] = '{0, 1, 2, 4, 5, 6, 7, 6, 7, 4, 4, 5, 3};
    logic [31:0] as[13]  = '{32'h7, 32'h7, 32'h7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 100, 100,
                             100, 100, 6, 32'h8000_0000, 32'h8000_0000, 32'h1234};
    logic [31:0] bs[13]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 2, 2, 7, 7, 0, 0,
                             3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5678};
    logic [31:0] exp[13] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h6, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'hE, 32'h2, 32'hFFFF_FFFF, 32'h64, 32'h2,
                             32'h8000_0000, 32'h0, 32'h0};
    logic        edz[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] res;
    logic        dz;
    int          lat, bcnt;
    for (int i = 0; i < 13; i++) begin
      // Reserved op follows a divide-by-zero so the div_zero clear is observable.
      if (i == 12) begin
        run_op(3'd6, 32'h5, 32'h0, res, dz, lat, bcnt);
        @(negedge clk);
      end
      run_op(ops[i], as[i], bs[i], res, dz, lat, bcnt);
      checks++;
      if (res !== exp[i] || dz !== edz[i]) begin
        failures++;
        $display("FAIL directed[%0d] op=%0d: result=%h div_zero=%b, want %h/%b",
                 i, ops[i], res, dz, exp[i], edz[i]);
      end
      checks++;
      if (lat != 33 || bcnt != 32) begin
        failures++;
        $display("FAIL latency[%0d]: done_cycle=%0d busy_cycles=%0d, want 33/32", i, lat, bcnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp[i]) begin
        failures++;
        $display("FAIL hold[%0d]: done=%b busy=%b result=%h, want 0/0/%h",
                 i, done, busy, result, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] special[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        dz;
    int          lat, bcnt;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 31);
      run_op(op, a, b, res, dz, lat, bcnt);
      checks++;
      if (res !== ref_res(op, a, b) || dz !== ref_dz(op, b) || lat != 33) begin
        failures++;
        $display("FAIL random op=%0d a=%h b=%h: result=%h dz=%b lat=%0d, want %h/%b/33",
                 op, a, b, res, dz, lat, ref_res(op, a, b), ref_dz(op, b));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, prev;
    logic        dz;
    int          lat, bcnt, cyc, dones;
    run_op(3'd6, 32'd77, 32'd5, prev, dz, lat, bcnt);
    @(negedge clk);
    md_op = 3'd4; src_a = 32'hFFFF_FF9C; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    dones = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      dones += done ? 1 : 0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dones += done ? 1 : 0;
    checks++;
    if (busy !== 1'b0 || dones != 0 || result !== prev) begin
      failures++;
      $display("FAIL flush_calc: busy=%b dones=%0d result=%h, want 0/0/%h",
               busy, dones, result, prev);
    end
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, res, dz, lat, bcnt);
    checks++;
    if (res !== 32'hFFFF_FFF2 || lat != 33) begin
      failures++;
      $display("FAIL flush_restart: result=%h lat=%0d, want fffffff2/33", res, lat);
    end
    // Flush together with start while idle drops the start.
    @(negedge clk);
    md_op = 3'd6; src_a = 32'd9; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    dones = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle: busy=%b, want 0", busy);
    end
    repeat (36) begin
      @(negedge clk);
      dones += done ? 1 : 0;
    end
    checks++;
    if (dones != 0 || result !== 32'hFFFF_FFF2) begin
      failures++;
      $display("FAIL flush_start_idle_done: dones=%0d result=%h, want 0/fffffff2", dones, result);
    end
    // Flush in FIN: done already pulsing, and a same-cycle start is dropped.
    run_op(3'd7, 32'd50, 32'd8, res, dz, lat, bcnt);
    md_op = 3'd6; src_a = 32'd9; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd2) begin
      failures++;
      $display("FAIL flush_fin: busy=%b done=%b result=%h, want 0/0/2", busy, done, result);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    md_op = 3'd4; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        md_op = 3'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (result !== 32'd142 || cyc != 33) begin
      failures++;
      $display("FAIL start_ignored: result=%h done_cycle=%0d, want 0000008e/33", result, cyc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_queue: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        dz;
    int          lat, bcnt;
    md_op = 3'd4; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b div_zero=%b result=%h, want 0/0/0/0",
               busy, done, div_zero, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, res, dz, lat, bcnt);
    checks++;
    if (res !== 32'h4000_0000 || lat != 33) begin
      failures++;
      $display("FAIL reset_recover: result=%h lat=%0d, want 40000000/33", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic        dz;
    int          lat, bcnt;
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, bcnt);
    checks++;
    if (res !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL b2b_first: result=%h, want fffffffe", res);
    end
    // Issued while done is high: accepted from FIN with no idle cycle.
    run_op(3'd5, 32'hFFFF_FF9C, 32'hFFFF_FFF9, res, dz, lat, bcnt);
    checks++;
    if (res !== 32'hFFFF_FFFE || bcnt != 32 || lat != 33) begin
      failures++;
      $display("FAIL b2b_second: result=%h busy_cycles=%0d lat=%0d, want fffffffe/32/33",
               res, bcnt, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
